// File: rtl/blake_pkg.sv
// Shared types and defaults for the miner work-loading path.
package blake_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } rx_state_t;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned TIMEOUT_DEFAULT   = 32'h0080_0000;

endpackage

// File: rtl/work_hold_reg.sv
// Valid/ready holding register: a load lands one cycle after load_vld.
// A load into a full, unaccepted register is dropped and flagged with err_overrun.
module work_hold_reg #(
  parameter int unsigned W = 416
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_vld,
  input  logic [W-1:0] load_dat,
  output logic [W-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         err_overrun
);

  logic can_load;

  assign can_load = !data_valid || data_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_overrun <= load_vld && !can_load;
      // A reload in the consume cycle keeps data_valid high.
      if (load_vld && can_load) begin
        data_out   <= load_dat;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/work_receive_framed.sv
// Framed work receiver: sync hunt, payload shift-in, optional XOR check, held output.
// Last byte in cycle N -> data_valid in N+2; a full holder drops new frames (err_overrun).
module work_receive_framed
  import blake_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES  = 52,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter bit          CHECK_EN       = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_byte,
  output logic [8*PAYLOAD_BYTES-1:0] data_out,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic                       err_timeout,
  output logic                       err_checksum,
  output logic                       err_overrun
);

  localparam int DW = 8 * PAYLOAD_BYTES;
  localparam int CW = $clog2(PAYLOAD_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(PAYLOAD_BYTES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

  rx_state_t     state_q, state_d;
  logic [DW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    xor_q, xor_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          err_to_d, err_ck_d;
  logic          timed_out;
  logic          commit;

  assign timed_out = ((state_q == LOAD) || (state_q == CHECK)) && (tmr_q == TMO_MAX);
  assign commit    = (state_q == COMMIT);

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    xor_d    = xor_q;
    tmr_d    = tmr_q;
    err_to_d = 1'b0;
    err_ck_d = 1'b0;
    case (state_q)
      // COMMIT lasts one cycle and hunts like HUNT does.
      HUNT, COMMIT: begin
        state_d = HUNT;
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          state_d = LOAD;
          cnt_d   = '0;
          xor_d   = 8'h00;
          tmr_d   = '0;
        end
      end
      LOAD: begin
        if (timed_out) begin
          state_d  = HUNT;
          err_to_d = 1'b1;
        end else if (rx_valid) begin
          buf_d = (buf_q << 8) | DW'(rx_byte);
          xor_d = xor_q ^ rx_byte;
          cnt_d = cnt_q + 1'b1;
          tmr_d = '0;
          if (cnt_q == LAST_IDX) begin
            state_d = CHECK_EN ? CHECK : COMMIT;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      CHECK: begin
        if (timed_out) begin
          state_d  = HUNT;
          err_to_d = 1'b1;
        end else if (rx_valid) begin
          tmr_d = '0;
          if (rx_byte == xor_q) begin
            state_d = COMMIT;
          end else begin
            state_d  = HUNT;
            err_ck_d = 1'b1;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      buf_q        <= '0;
      cnt_q        <= '0;
      xor_q        <= 8'h00;
      tmr_q        <= '0;
      err_timeout  <= 1'b0;
      err_checksum <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      xor_q        <= xor_d;
      tmr_q        <= tmr_d;
      err_timeout  <= err_to_d;
      err_checksum <= err_ck_d;
    end
  end

  work_hold_reg #(
    .W(DW)
  ) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_vld   (commit),
    .load_dat   (buf_q),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .err_overrun(err_overrun)
  );

endmodule

// File: tb/tb_work_receive_framed.sv
// Bench: 4-byte checked receiver against a queue-based frame model, plus a default 52-byte unchecked instance.
module tb_work_receive_framed;

  localparam int TB_P   = 4;
  localparam int TB_TMO = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic [31:0]  data_out;
  logic         data_valid;
  logic         data_ready = 1'b0;
  logic         err_timeout, err_checksum, err_overrun;

  logic         rx_valid_b = 1'b0;
  logic [7:0]   rx_byte_b = 8'h00;
  logic [415:0] data_out_b;
  logic         data_valid_b;
  logic         data_ready_b = 1'b0;
  logic         err_timeout_b, err_checksum_b, err_overrun_b;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  work_receive_framed #(
    .PAYLOAD_BYTES (TB_P),
    .TIMEOUT_CYCLES(TB_TMO),
    .SYNC_BYTE     (8'hA5),
    .CHECK_EN      (1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .err_timeout(err_timeout), .err_checksum(err_checksum), .err_overrun(err_overrun)
  );

  work_receive_framed #(
    .PAYLOAD_BYTES(52),
    .CHECK_EN     (1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid_b), .rx_byte(rx_byte_b),
    .data_out(data_out_b), .data_valid(data_valid_b), .data_ready(data_ready_b),
    .err_timeout(err_timeout_b), .err_checksum(err_checksum_b), .err_overrun(err_overrun_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: bytes are collected in a queue, the checksum is the XOR of the queue.
  logic [7:0]  m_q[$];
  bit          m_in = 0, m_commit = 0, m_take = 0;
  int          m_idle = 0;
  logic [31:0] m_frame = '0, m_out = '0;
  logic        m_valid = 0, m_to = 0, m_ck = 0, m_ov = 0;

  function automatic logic [7:0] q_xor();
    logic [7:0] x = 8'h00;
    foreach (m_q[i]) x ^= m_q[i];
    return x;
  endfunction

  function automatic logic [31:0] q_pack();
    logic [31:0] r = '0;
    foreach (m_q[i]) r = {r[23:0], m_q[i]};
    return r;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_in = 0; m_commit = 0; m_idle = 0; m_frame = '0;
      m_out = '0; m_valid = 0; m_to = 0; m_ck = 0; m_ov = 0;
    end else begin
      m_take = m_valid && data_ready;
      m_to = 0; m_ck = 0; m_ov = 0;
      if (m_commit) begin
        m_commit = 0;
        if (!m_valid || data_ready) begin
          m_out = m_frame; m_valid = 1; m_take = 0;
        end else begin
          m_ov = 1;
        end
      end
      if (m_take) m_valid = 0;
      if (m_in) begin
        if (m_idle == TB_TMO) begin
          m_in = 0; m_to = 1;
        end else if (rx_valid) begin
          m_idle = 0;
          if (m_q.size() < TB_P) begin
            m_q.push_back(rx_byte);
          end else begin
            m_in = 0;
            if (rx_byte == q_xor()) begin
              m_commit = 1; m_frame = q_pack();
            end else begin
              m_ck = 1;
            end
          end
        end else begin
          m_idle++;
        end
      end else if (rx_valid && rx_byte == 8'hA5) begin
        m_in = 1; m_q.delete(); m_idle = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("valid", 32'(data_valid), 32'(m_valid));
      chk("dout", data_out, m_out);
      chk("err_to", 32'(err_timeout), 32'(m_to));
      chk("err_ck", 32'(err_checksum), 32'(m_ck));
      chk("err_ov", 32'(err_overrun), 32'(m_ov));
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) data_ready = ($urandom_range(0, 7) == 0);
  end

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    rx_valid_b = 1'b1; rx_byte_b = b;
    @(posedge clk); #1;
    rx_valid_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame(input logic [31:0] p, input logic [7:0] ck);
    send(8'hA5);
    for (int i = 3; i >= 0; i--) send(p[8*i +: 8]);
    send(ck);
  endtask

  function automatic int pick_gap();
    int r = $urandom_range(0, 19);
    if (r < 12) return 0;
    if (r < 17) return r - 11;
    if (r == 17) return TB_TMO - 1;
    return TB_TMO;
  endfunction

  initial begin
    int n;
    logic [7:0] p;
    logic [7:0] x;
    int kind;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_dout", data_out, 32'd0);

    // Clean frame: data_valid two cycles after the checksum byte.
    frame(32'h11223344, 8'h44);
    chk("clean_n1_valid", 32'(data_valid), 32'd0);
    idle(1);
    chk("clean_valid", 32'(data_valid), 32'd1);
    chk("clean_dout", data_out, 32'h11223344);

    data_ready = 1'b1; idle(2); data_ready = 1'b0;
    frame(32'h11223344, 8'h45);
    chk("badck_pulse", 32'(err_checksum), 32'd1);
    idle(1);
    chk("badck_once", 32'(err_checksum), 32'd0);
    chk("badck_valid", 32'(data_valid), 32'd0);
    frame(32'h01020304, 8'h04);
    idle(1);
    chk("after_bad_dout", data_out, 32'h01020304);

    // Timeout: pulse two cycles past the limit count of idle cycles after the last byte.
    data_ready = 1'b1; idle(2); data_ready = 1'b0;
    send(8'hA5); send(8'h11);
    n = 0;
    while (!err_timeout && n < 40) begin @(posedge clk); #1; n++; end
    chk("to_latency", 32'(n), 32'(TB_TMO + 1));
    frame(32'h55667788, 8'hCC);
    idle(1);
    chk("after_to_dout", data_out, 32'h55667788);

    // Overrun: second frame dropped while the first is held.
    data_ready = 1'b1; idle(2); data_ready = 1'b0;
    frame(32'hAABBCCDD, 8'h00);
    frame(32'h01234567, 8'h00);
    idle(1);
    chk("ovr_pulse", 32'(err_overrun), 32'd1);
    chk("ovr_dout", data_out, 32'hAABBCCDD);
    data_ready = 1'b1; idle(1);
    chk("ovr_drain", 32'(data_valid), 32'd0);
    data_ready = 1'b0;

    // Accept and reload in the COMMIT cycle.
    frame(32'hAABBCCDD, 8'h00);
    frame(32'h01234567, 8'h00);
    data_ready = 1'b1; idle(1);
    chk("reload_valid", 32'(data_valid), 32'd1);
    chk("reload_dout", data_out, 32'h01234567);
    chk("reload_no_ovr", 32'(err_overrun), 32'd0);
    data_ready = 1'b0;

    // Asynchronous reset mid-LOAD.
    send(8'hA5); send(8'h12);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(data_valid), 32'd0);
    chk("arst_dout", data_out, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'h00); send(8'hFF);
    frame(32'h9ABCDEF0, 8'h08);
    idle(1);
    chk("garbage_dout", data_out, 32'h9ABCDEF0);

    // Randomized traffic against the model.
    rand_ready = 1'b1;
    for (int f = 0; f < 250; f++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) send(8'($urandom_range(0, 255)));
      send(8'hA5);
      x = 8'h00;
      for (int i = 0; i < TB_P; i++) begin
        p = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
        x ^= p;
        idle(pick_gap());
        send(p);
      end
      if (kind == 0) x ^= 8'(1 << $urandom_range(0, 7));
      if (kind == 1) begin
        idle(TB_TMO + 4);
      end else begin
        idle(pick_gap());
        send(x);
      end
      idle($urandom_range(0, 2));
    end
    rand_ready = 1'b0;
    data_ready = 1'b0;
    idle(4);

    // Default 52-byte instance, no checksum byte; sync value inside payload is data.
    send_b(8'h00); send_b(8'hFF); send_b(8'hA5);
    for (int i = 0; i < 52; i++) send_b((i == 9) ? 8'hA5 : 8'(i + 1));
    chk("b52_n1_valid", 32'(data_valid_b), 32'd0);
    idle(1);
    chk("b52_valid", 32'(data_valid_b), 32'd1);
    chk("b52_top", data_out_b[415:384], 32'h01020304);
    chk("b52_sync_data", 32'(data_out_b[8*42 +: 8]), 32'h000000A5);
    chk("b52_last", 32'(data_out_b[7:0]), 32'h00000034);
    chk("b52_no_err", 32'({err_timeout_b, err_checksum_b, err_overrun_b}), 32'd0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
